// File: rtl/ex_div_pkg.sv
// ex_div_pkg -- shared constants for the EX-stage divider.
//   State encodings, result/ready constants, iteration count, and a helper
//   that returns the magnitude of a two's-complement operand.
package ex_div_pkg;

   localparam logic [1:0]  DIV_FREE          = 2'b00;
   localparam logic [1:0]  DIV_BY_ZERO       = 2'b01;
   localparam logic [1:0]  DIV_ON            = 2'b10;
   localparam logic [1:0]  DIV_END           = 2'b11;

   localparam logic        DIV_READY         = 1'b1;
   localparam logic        DIV_NOT_READY     = 1'b0;
   localparam logic [63:0] DIV_ZERO_RESULT   = 64'h0;
   localparam logic [5:0]  DIV_ITERATIONS    = 6'd32;

   // Magnitude of v when signed interpretation is requested; 0x80000000 maps
   // to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_div.sv
// ex_div -- 32-bit restoring divider for the EX stage (DIV / DIVU).
//   One quotient bit per cycle; sign handled by dividing magnitudes and
//   fixing up the result at the end.
// Ports:
//   clk              sole clock
//   rst              synchronous active-high reset
//   div_start        divide request, held until ready
//   div_signed       1 = DIV, 0 = DIVU (sampled at acceptance)
//   div_annul        abort, return to idle
//   opdata1/opdata2  dividend / divisor (sampled at acceptance)
//   div_result       {remainder, quotient}, valid while ready
//   ready            result valid (registered)
//   stallreq_for_div pipeline stall request (combinational)
//
// state       | meaning
// ------------+------------------------------------------------
// DIV_FREE    | idle, waiting for div_start
// DIV_BY_ZERO | divisor was zero, result forced to 0
// DIV_ON      | iterating, one restoring step per cycle
// DIV_END     | result presented, wait for div_start to drop
module ex_div
   import ex_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        div_start,
   input  logic        div_signed,
   input  logic        div_annul,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   output logic [63:0] div_result,
   output logic        ready,
   output logic        stallreq_for_div
);

   logic [1:0]  state_q;
   logic [5:0]  cnt_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] divisor_q;
   logic        neg_quot_q;
   logic        neg_rem_q;

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        take;

   // quo_q starts as the dividend and fills with quotient bits from the
   // bottom as the dividend bits shift out into the partial remainder.
   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {1'b0, divisor_q};
   assign take    = ~diff[32];

   assign stallreq_for_div = div_start & (state_q != DIV_END);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DIV_FREE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         divisor_q  <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         ready      <= DIV_NOT_READY;
         div_result <= DIV_ZERO_RESULT;
      end else if (div_annul) begin
         state_q    <= DIV_FREE;
         cnt_q      <= '0;
         ready      <= DIV_NOT_READY;
         div_result <= DIV_ZERO_RESULT;
      end else begin
         case (state_q)
            DIV_FREE: begin
               if (div_start) begin
                  neg_quot_q <= div_signed & (opdata1[31] ^ opdata2[31]);
                  neg_rem_q  <= div_signed & opdata1[31];
                  quo_q      <= abs32(opdata1, div_signed);
                  divisor_q  <= abs32(opdata2, div_signed);
                  rem_q      <= '0;
                  cnt_q      <= '0;
                  state_q    <= (opdata2 == 32'h0) ? DIV_BY_ZERO : DIV_ON;
               end
            end
            DIV_BY_ZERO: begin
               state_q    <= DIV_END;
               ready      <= DIV_READY;
               div_result <= DIV_ZERO_RESULT;
            end
            DIV_ON: begin
               if (cnt_q == DIV_ITERATIONS) begin
                  state_q    <= DIV_END;
                  ready      <= DIV_READY;
                  div_result <= {neg_if(rem_q, neg_rem_q), neg_if(quo_q, neg_quot_q)};
               end else begin
                  rem_q <= take ? diff[31:0] : shifted[31:0];
                  quo_q <= {quo_q[30:0], take};
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            DIV_END: begin
               if (!div_start) begin
                  state_q    <= DIV_FREE;
                  ready      <= DIV_NOT_READY;
                  div_result <= DIV_ZERO_RESULT;
               end
            end
            default: state_q <= DIV_FREE;
         endcase
      end
   end

endmodule
